eq_scheduler: RTL and testbench
===============================

# eq_scheduler

Sequencing and arbitration controller for the shared two-equation datapath: altitude A = x1*3 + x2*5 (sel_eq=0), battery B = v*t + c (sel_eq=1). It accepts operand requests from an altitude requester and a battery requester, and a self-test request that launches the BIST sequencer. It owns the datapath operand/select inputs and waits a fixed pipeline latency before capturing each result. It returns each captured result to its requester with a one-cycle done pulse.

## Interface
- LATENCY, 4: cycles from operand presentation to a valid result_a/result_b (≥1)
- BIST_TIMEOUT, 32: max cycles in BIST_RUN before self-test is declared failed
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- alt_req  in  1  altitude request; held high with operands stable until alt_done
- alt_x1, alt_x2  in  8 each  altitude operands
- bat_req  in  1  battery request; same protocol as alt_req
- bat_v, bat_t, bat_c  in  8 each  battery operands
- bist_req  in  1  self-test request level
- bist_x1, bist_x2, bist_v, bist_t, bist_c  in  8 each  BIST test vectors
- bist_sel_eq  in  1  BIST equation select
- bist_active, bist_pass  in  1 each  BIST sequencer status
- result_a, result_b  in  16 each  datapath results
- dp_x1, dp_x2, dp_v, dp_t, dp_c  out  8 each  datapath operands
- dp_sel_eq  out  1  datapath equation select
- start_bist  out  1  one-cycle BIST launch pulse
- alt_done / bat_done  out  1 each  one-cycle completion pulse
- alt_result / bat_result  out  16 each  captured result, held until next completion for that requester
- bist_done  out  1  one-cycle self-test completion pulse
- bist_ok  out  1  latched self-test verdict
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, DONE, BIST_START, BIST_RUN, BIST_SAMPLE.
- IDLE priority: bist_req > round-robin(alt_req, bat_req). On a tie, grant the requester not granted last. last_grant resets to BAT, so the first tie goes to ALT.
- Grant (IDLE→WAIT): capture the winner's operands and its select (ALT→0, BAT→1) into internal registers. Clear wait counter.
- WAIT: dp_* driven from the captured registers; the unused operand fields are 0. The counter increments each cycle. On the LATENCY-th WAIT cycle, sample result_a (ALT) or result_b (BAT) into the requester's result register, then go to DONE.
- DONE: the granted requester's done is high for exactly one cycle. Update last_grant. Next state is IDLE.
- Requester protocol: drop req on the edge that samples done=1. IDLE therefore never re-grants a completed request. If req drops mid-transaction, the transaction still completes and done still pulses.
- BIST_START: start_bist=1 for one cycle, then go to BIST_RUN. Clear the timeout counter and seen_active.
- BIST_RUN: set seen_active when bist_active=1. When seen_active=1 and bist_active=0, go to BIST_SAMPLE. If the counter reaches BIST_TIMEOUT first: bist_ok←0, bist_done pulse, go to IDLE.
- BIST_SAMPLE: bist_ok←bist_pass at end of cycle; bist_done=1 this cycle. Next state is IDLE.
- During BIST_START/RUN/SAMPLE, dp_* and dp_sel_eq pass bist_* through combinationally.
- In IDLE, all dp_* and dp_sel_eq are 0.
- bist_req arriving during WAIT/DONE waits; the transaction in flight always completes first.
- No arithmetic is performed here; results are captured unmodified at 16 bits.

## Timing
- Reset (synchronous) forces state=IDLE and all outputs to 0, including start_bist, done pulses, busy, results, bist_ok, bist_done, and dp_*.
- Reset also clears last_grant←BAT and all counters.
- Reset mid-transaction or mid-BIST aborts with no done pulse.
- Request first high in IDLE at cycle 0 gives: grant edge end of cycle 0, WAIT cycles 1..LATENCY, done in cycle LATENCY+1, busy in cycles 1..LATENCY+1.
- Back-to-back: another pending request is granted from IDLE in cycle LATENCY+2. Minimum period per transaction is LATENCY+2 cycles.
- bist_req in IDLE at cycle 0 gives start_bist in cycle 1, BIST_RUN from cycle 2.
- bist_done fires one cycle after bist_active's falling edge is observed, or on timeout.
- All outputs except dp_* and dp_sel_eq are registered.

## Test plan
- ALT single: LATENCY=4, alt_x1=3, alt_x2=4, result_a model returns 29 after 4 cycles → dp_sel_eq=0 in cycles 1–4, alt_done in cycle 5 with alt_result=29, bat_done never.
- BAT single: bat_v=2, bat_t=5, bat_c=16, result_b=26 → dp_sel_eq=1, bat_done in cycle 5 with bat_result=26, alt_result unchanged.
- Tie/round-robin: alt_req and bat_req high together from reset, each dropped on its done → ALT served first (done cycle 5), BAT second (done cycle 11). A second simultaneous pair again alternates.
- BIST priority: bist_req, alt_req, bat_req all high in IDLE; connected BIST sequencer passes → start_bist in cycle 1, dp_* mirror bist_* (3/4 then 2/5/16), bist_done with bist_ok=1, then ALT and BAT served.
- BIST timeout: bist_active held 0 → bist_done exactly BIST_TIMEOUT cycles into BIST_RUN, bist_ok=0.
- Reset mid-WAIT: rst in cycle 3 of an ALT transaction → all outputs 0 the next cycle, no alt_done. A fresh request completes normally with LATENCY+1 latency.

Source files
------------

// File: rtl/eq_scheduler.sv
// Arbitrates altitude/battery/BIST requests onto the shared equation datapath.
// Latency LATENCY+1 cycles grant-to-done; requesters hold req until their done pulse.
module eq_scheduler #(
    parameter int LATENCY      = 4,
    parameter int BIST_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alt_req,
    input  logic [7:0]  alt_x1,
    input  logic [7:0]  alt_x2,
    input  logic        bat_req,
    input  logic [7:0]  bat_v,
    input  logic [7:0]  bat_t,
    input  logic [7:0]  bat_c,
    input  logic        bist_req,
    input  logic [7:0]  bist_x1,
    input  logic [7:0]  bist_x2,
    input  logic [7:0]  bist_v,
    input  logic [7:0]  bist_t,
    input  logic [7:0]  bist_c,
    input  logic        bist_sel_eq,
    input  logic        bist_active,
    input  logic        bist_pass,
    input  logic [15:0] result_a,
    input  logic [15:0] result_b,
    output logic [7:0]  dp_x1,
    output logic [7:0]  dp_x2,
    output logic [7:0]  dp_v,
    output logic [7:0]  dp_t,
    output logic [7:0]  dp_c,
    output logic        dp_sel_eq,
    output logic        start_bist,
    output logic        alt_done,
    output logic        bat_done,
    output logic [15:0] alt_result,
    output logic [15:0] bat_result,
    output logic        bist_done,
    output logic        bist_ok,
    output logic        busy
);

    localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int BCW = (BIST_TIMEOUT > 1) ? $clog2(BIST_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        IDLE, WAIT, DONE, BIST_START, BIST_RUN, BIST_SAMPLE
    } state_t;

    state_t         state;
    logic           cur_bat;
    logic           last_grant;
    logic           seen_active;
    logic [WCW-1:0] wait_cnt;
    logic [BCW-1:0] bist_cnt;
    logic [7:0]     op_x1, op_x2, op_v, op_t, op_c;
    logic           op_sel;
    logic           pick_bat;

    // Round robin on a tie: BAT only wins if ALT was served last.
    assign pick_bat = bat_req && (!alt_req || !last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_bat     <= 1'b0;
            last_grant  <= 1'b1;
            seen_active <= 1'b0;
            wait_cnt    <= '0;
            bist_cnt    <= '0;
            op_x1       <= '0;
            op_x2       <= '0;
            op_v        <= '0;
            op_t        <= '0;
            op_c        <= '0;
            op_sel      <= 1'b0;
            start_bist  <= 1'b0;
            alt_done    <= 1'b0;
            bat_done    <= 1'b0;
            alt_result  <= '0;
            bat_result  <= '0;
            bist_done   <= 1'b0;
            bist_ok     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            start_bist <= 1'b0;
            alt_done   <= 1'b0;
            bat_done   <= 1'b0;
            bist_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bist_req) begin
                        state      <= BIST_START;
                        start_bist <= 1'b1;
                        busy       <= 1'b1;
                    end else if (alt_req || bat_req) begin
                        state    <= WAIT;
                        busy     <= 1'b1;
                        cur_bat  <= pick_bat;
                        wait_cnt <= '0;
                        op_sel   <= pick_bat;
                        op_x1    <= pick_bat ? 8'd0 : alt_x1;
                        op_x2    <= pick_bat ? 8'd0 : alt_x2;
                        op_v     <= pick_bat ? bat_v : 8'd0;
                        op_t     <= pick_bat ? bat_t : 8'd0;
                        op_c     <= pick_bat ? bat_c : 8'd0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WCW'(LATENCY - 1)) begin
                        state <= DONE;
                        if (cur_bat) begin
                            bat_result <= result_b;
                            bat_done   <= 1'b1;
                        end else begin
                            alt_result <= result_a;
                            alt_done   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                DONE: begin
                    last_grant <= cur_bat;
                    state      <= IDLE;
                    busy       <= 1'b0;
                end
                BIST_START: begin
                    bist_cnt    <= '0;
                    seen_active <= 1'b0;
                    state       <= BIST_RUN;
                end
                BIST_RUN: begin
                    if (bist_active)
                        seen_active <= 1'b1;
                    if (seen_active && !bist_active) begin
                        state     <= BIST_SAMPLE;
                        bist_done <= 1'b1;
                    end else if (bist_cnt == BCW'(BIST_TIMEOUT - 1)) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bist_ok   <= 1'b0;
                        bist_done <= 1'b1;
                    end else begin
                        bist_cnt <= bist_cnt + BCW'(1);
                    end
                end
                BIST_SAMPLE: begin
                    bist_ok <= bist_pass;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand steering is combinational so BIST vectors reach the datapath the same cycle.
    always_comb begin
        dp_x1     = 8'd0;
        dp_x2     = 8'd0;
        dp_v      = 8'd0;
        dp_t      = 8'd0;
        dp_c      = 8'd0;
        dp_sel_eq = 1'b0;
        case (state)
            WAIT, DONE: begin
                dp_x1     = op_x1;
                dp_x2     = op_x2;
                dp_v      = op_v;
                dp_t      = op_t;
                dp_c      = op_c;
                dp_sel_eq = op_sel;
            end
            BIST_START, BIST_RUN, BIST_SAMPLE: begin
                dp_x1     = bist_x1;
                dp_x2     = bist_x2;
                dp_v      = bist_v;
                dp_t      = bist_t;
                dp_c      = bist_c;
                dp_sel_eq = bist_sel_eq;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eq_scheduler.sv
// Directed bench for eq_scheduler with a 3-register datapath model behind it.
module tb_eq_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alt_req = 1'b0, bat_req = 1'b0, bist_req = 1'b0;
    logic [7:0]  alt_x1 = '0, alt_x2 = '0, bat_v = '0, bat_t = '0, bat_c = '0;
    logic [7:0]  bist_x1 = '0, bist_x2 = '0, bist_v = '0, bist_t = '0, bist_c = '0;
    logic        bist_sel_eq = 1'b0, bist_active = 1'b0, bist_pass = 1'b0;
    logic [15:0] result_a, result_b;
    logic [7:0]  dp_x1, dp_x2, dp_v, dp_t, dp_c;
    logic        dp_sel_eq, start_bist, alt_done, bat_done, bist_done, bist_ok, busy;
    logic [15:0] alt_result, bat_result;

    int vecs = 0;
    int errs = 0;

    eq_scheduler #(.LATENCY(4), .BIST_TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .alt_req(alt_req), .alt_x1(alt_x1), .alt_x2(alt_x2),
        .bat_req(bat_req), .bat_v(bat_v), .bat_t(bat_t), .bat_c(bat_c),
        .bist_req(bist_req), .bist_x1(bist_x1), .bist_x2(bist_x2),
        .bist_v(bist_v), .bist_t(bist_t), .bist_c(bist_c),
        .bist_sel_eq(bist_sel_eq), .bist_active(bist_active), .bist_pass(bist_pass),
        .result_a(result_a), .result_b(result_b),
        .dp_x1(dp_x1), .dp_x2(dp_x2), .dp_v(dp_v), .dp_t(dp_t), .dp_c(dp_c),
        .dp_sel_eq(dp_sel_eq), .start_bist(start_bist),
        .alt_done(alt_done), .bat_done(bat_done),
        .alt_result(alt_result), .bat_result(bat_result),
        .bist_done(bist_done), .bist_ok(bist_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    // Datapath model: operands presented in WAIT cycle 1 are valid on result_* in WAIT cycle 4.
    logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0, pb0 = '0, pb1 = '0, pb2 = '0;
    always @(posedge clk) begin
        pa0 <= {8'd0, dp_x1} * 16'd3 + {8'd0, dp_x2} * 16'd5;
        pb0 <= {8'd0, dp_v} * {8'd0, dp_t} + {8'd0, dp_c};
        pa1 <= pa0; pa2 <= pa1;
        pb1 <= pb0; pb2 <= pb1;
    end
    assign result_a = pa2;
    assign result_b = pb2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++;
        if ({busy, start_bist, alt_done, bat_done, bist_done, bist_ok} !== 6'd0) begin
            errs++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, start_bist, alt_done, bat_done, bist_done, bist_ok});
        end
        vecs++;
        if ({alt_result, bat_result} !== 32'd0) begin
            errs++;
            $display("FAIL reset_results: got %0d/%0d want 0/0", alt_result, bat_result);
        end
        vecs++;
        if ({dp_x1, dp_x2, dp_v, dp_t, dp_c, dp_sel_eq} !== 41'd0) begin
            errs++;
            $display("FAIL reset_dp: got %h want 0", {dp_x1, dp_x2, dp_v, dp_t, dp_c, dp_sel_eq});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_alt_single();
        int bad = 0;
        alt_x1 = 8'd3; alt_x2 = 8'd4; alt_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (dp_sel_eq !== 1'b0 || dp_x1 !== 8'd3 || dp_x2 !== 8'd4 || dp_v !== 8'd0 ||
                busy !== 1'b1 || alt_done !== 1'b0 || bat_done !== 1'b0)
                bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL alt_wait: %0d bad WAIT cycles, want 0", bad);
        end
        tick();
        vecs++;
        if (alt_done !== 1'b1 || alt_result !== 16'd29 || bat_done !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL alt_done: done=%b result=%0d bat_done=%b busy=%b want 1/29/0/1",
                     alt_done, alt_result, bat_done, busy);
        end
        alt_req = 1'b0;
        tick();
        vecs++;
        if (alt_done !== 1'b0 || busy !== 1'b0 || dp_x1 !== 8'd0) begin
            errs++;
            $display("FAIL alt_idle: done=%b busy=%b dp_x1=%0d want 0/0/0", alt_done, busy, dp_x1);
        end
    endtask

    task automatic test_bat_single();
        int bad = 0;
        bat_v = 8'd2; bat_t = 8'd5; bat_c = 8'd16; bat_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (dp_sel_eq !== 1'b1 || dp_v !== 8'd2 || dp_t !== 8'd5 || dp_c !== 8'd16 ||
                dp_x1 !== 8'd0 || dp_x2 !== 8'd0 || bat_done !== 1'b0)
                bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL bat_wait: %0d bad WAIT cycles, want 0", bad);
        end
        tick();
        vecs++;
        if (bat_done !== 1'b1 || bat_result !== 16'd26 || alt_result !== 16'd29 || alt_done !== 1'b0) begin
            errs++;
            $display("FAIL bat_done: done=%b result=%0d alt_result=%0d alt_done=%b want 1/26/29/0",
                     bat_done, bat_result, alt_result, alt_done);
        end
        bat_req = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        // First tie after reset goes to ALT; BAT follows at LATENCY+2 spacing.
        alt_x1 = 8'd3; alt_x2 = 8'd4; bat_v = 8'd2; bat_t = 8'd5; bat_c = 8'd16;
        alt_req = 1'b1; bat_req = 1'b1;
        repeat (5) tick();
        vecs++;
        if (alt_done !== 1'b1 || bat_done !== 1'b0 || alt_result !== 16'd29) begin
            errs++;
            $display("FAIL tie1_alt: alt_done=%b bat_done=%b result=%0d want 1/0/29",
                     alt_done, bat_done, alt_result);
        end
        alt_req = 1'b0;
        repeat (6) tick();
        vecs++;
        if (bat_done !== 1'b1 || bat_result !== 16'd26) begin
            errs++;
            $display("FAIL tie1_bat: bat_done=%b result=%0d want 1/26", bat_done, bat_result);
        end
        bat_req = 1'b0;
        tick();
        alt_x1 = 8'd1; alt_x2 = 8'd1; bat_v = 8'd3; bat_t = 8'd3; bat_c = 8'd1;
        alt_req = 1'b1; bat_req = 1'b1;
        repeat (5) tick();
        vecs++;
        if (alt_done !== 1'b1 || bat_done !== 1'b0 || alt_result !== 16'd8) begin
            errs++;
            $display("FAIL tie2_alt: alt_done=%b bat_done=%b result=%0d want 1/0/8",
                     alt_done, bat_done, alt_result);
        end
        alt_req = 1'b0;
        repeat (6) tick();
        vecs++;
        if (bat_done !== 1'b1 || bat_result !== 16'd10) begin
            errs++;
            $display("FAIL tie2_bat: bat_done=%b result=%0d want 1/10", bat_done, bat_result);
        end
        bat_req = 1'b0;
        tick();
        // ALT alone, then a tie must go to BAT.
        alt_x1 = 8'd2; alt_x2 = 8'd2; alt_req = 1'b1;
        repeat (5) tick();
        vecs++;
        if (alt_done !== 1'b1 || alt_result !== 16'd16) begin
            errs++;
            $display("FAIL solo_alt: alt_done=%b result=%0d want 1/16", alt_done, alt_result);
        end
        alt_req = 1'b0;
        tick();
        alt_x1 = 8'd1; alt_x2 = 8'd0; bat_v = 8'd1; bat_t = 8'd1; bat_c = 8'd1;
        alt_req = 1'b1; bat_req = 1'b1;
        repeat (5) tick();
        vecs++;
        if (bat_done !== 1'b1 || alt_done !== 1'b0 || bat_result !== 16'd2) begin
            errs++;
            $display("FAIL tie3_bat_first: bat_done=%b alt_done=%b result=%0d want 1/0/2",
                     bat_done, alt_done, bat_result);
        end
        bat_req = 1'b0;
        repeat (6) tick();
        vecs++;
        if (alt_done !== 1'b1 || alt_result !== 16'd3) begin
            errs++;
            $display("FAIL tie3_alt_second: alt_done=%b result=%0d want 1/3", alt_done, alt_result);
        end
        alt_req = 1'b0;
        tick();
    endtask

    task automatic test_bist_priority();
        do_reset();
        alt_x1 = 8'd3; alt_x2 = 8'd4; bat_v = 8'd2; bat_t = 8'd5; bat_c = 8'd16;
        alt_req = 1'b1; bat_req = 1'b1; bist_req = 1'b1;
        tick();
        vecs++;
        if (start_bist !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL bist_start: start_bist=%b busy=%b want 1/1", start_bist, busy);
        end
        bist_req = 1'b0;
        tick();
        bist_active = 1'b1; bist_x1 = 8'd3; bist_x2 = 8'd4; bist_sel_eq = 1'b0;
        #1;
        vecs++;
        if (start_bist !== 1'b0 || dp_x1 !== 8'd3 || dp_x2 !== 8'd4 || dp_sel_eq !== 1'b0) begin
            errs++;
            $display("FAIL bist_mirror_a: start=%b x1=%0d x2=%0d sel=%b want 0/3/4/0",
                     start_bist, dp_x1, dp_x2, dp_sel_eq);
        end
        tick();
        bist_x1 = 8'd0; bist_x2 = 8'd0; bist_v = 8'd2; bist_t = 8'd5; bist_c = 8'd16;
        bist_sel_eq = 1'b1;
        #1;
        vecs++;
        if (dp_v !== 8'd2 || dp_t !== 8'd5 || dp_c !== 8'd16 || dp_sel_eq !== 1'b1 || dp_x1 !== 8'd0) begin
            errs++;
            $display("FAIL bist_mirror_b: v=%0d t=%0d c=%0d sel=%b want 2/5/16/1",
                     dp_v, dp_t, dp_c, dp_sel_eq);
        end
        tick();
        bist_active = 1'b0; bist_pass = 1'b1;
        bist_v = 8'd0; bist_t = 8'd0; bist_c = 8'd0; bist_sel_eq = 1'b0;
        tick();
        vecs++;
        if (bist_done !== 1'b1 || alt_done !== 1'b0) begin
            errs++;
            $display("FAIL bist_done: bist_done=%b alt_done=%b want 1/0", bist_done, alt_done);
        end
        tick();
        vecs++;
        if (bist_done !== 1'b0 || bist_ok !== 1'b1) begin
            errs++;
            $display("FAIL bist_ok: bist_done=%b bist_ok=%b want 0/1", bist_done, bist_ok);
        end
        bist_pass = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (alt_done === 1'b1) break;
        end
        vecs++;
        if (alt_done !== 1'b1 || alt_result !== 16'd29) begin
            errs++;
            $display("FAIL bist_then_alt: alt_done=%b result=%0d want 1/29", alt_done, alt_result);
        end
        alt_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bat_done === 1'b1) break;
        end
        vecs++;
        if (bat_done !== 1'b1 || bat_result !== 16'd26) begin
            errs++;
            $display("FAIL bist_then_bat: bat_done=%b result=%0d want 1/26", bat_done, bat_result);
        end
        bat_req = 1'b0;
        tick();
    endtask

    task automatic test_bist_timeout();
        int bad = 0;
        bist_req = 1'b1;
        tick();
        vecs++;
        if (start_bist !== 1'b1) begin
            errs++;
            $display("FAIL to_start: start_bist=%b want 1", start_bist);
        end
        bist_req = 1'b0;
        for (int c = 2; c <= 33; c++) begin
            tick();
            if (bist_done !== 1'b0 || busy !== 1'b1) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL to_early: %0d bad BIST_RUN cycles, want 0", bad);
        end
        tick();
        vecs++;
        if (bist_done !== 1'b1 || bist_ok !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL to_done: bist_done=%b bist_ok=%b busy=%b want 1/0/0", bist_done, bist_ok, busy);
        end
        tick();
        vecs++;
        if (bist_done !== 1'b0) begin
            errs++;
            $display("FAIL to_pulse: bist_done=%b want 0", bist_done);
        end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        alt_x1 = 8'd3; alt_x2 = 8'd4; alt_req = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        vecs++;
        if (busy !== 1'b0 || alt_done !== 1'b0 || alt_result !== 16'd0 || dp_x1 !== 8'd0 || dp_x2 !== 8'd0) begin
            errs++;
            $display("FAIL rst_wait: busy=%b done=%b result=%0d dp=%0d/%0d want 0/0/0/0/0",
                     busy, alt_done, alt_result, dp_x1, dp_x2);
        end
        rst = 1'b0;
        alt_x1 = 8'd1; alt_x2 = 8'd1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (alt_done !== 1'b0) bad++;
        end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL rst_stray_done: %0d early done cycles, want 0", bad);
        end
        tick();
        vecs++;
        if (alt_done !== 1'b1 || alt_result !== 16'd8) begin
            errs++;
            $display("FAIL rst_restart: alt_done=%b result=%0d want 1/8", alt_done, alt_result);
        end
        alt_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alt_single();
        test_bat_single();
        test_round_robin();
        test_bist_priority();
        test_bist_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
